// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the CPU control path: opcode values, micro-step
// indices and the layout of the control word. The same names are used by
// the instruction register and ALU decode, so the encodings here are the
// single source of truth for the datapath.
package control_sequencer_pkg;

  // Upper nibble of the instruction register. Values 9..D are unassigned
  // and decode as NOP.
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Micro-step indices: T0/T1 fetch, T2..T4 execute.
  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  // Control word, every bit active-high. The program counter bus driver is
  // carried here as 'co' and only inverted to co_n at the block boundary,
  // so an all-zero word is the fully inactive word.
  typedef struct packed {
    logic mi;   // memory address register load
    logic ri;   // RAM write
    logic ro;   // RAM drives bus
    logic ii;   // instruction register load
    logic io;   // instruction operand drives bus
    logic ai;   // A register load
    logic ao;   // A register drives bus
    logic bi;   // B register load
    logic eo;   // ALU drives bus
    logic su;   // ALU subtract
    logic fi;   // flags register load
    logic oi;   // output register load
    logic ce;   // program counter count enable
    logic j;    // program counter load from bus
    logic co;   // program counter drives bus
    logic hlt;  // halt indicator
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Microcode ROM for the control sequencer. Purely combinational: maps the
// current opcode, micro-step and flags to a control word, and raises 'last'
// on the final step of the instruction so the step counter wraps to T0.
//
// Ports:
//   opcode  in   4  instruction register upper nibble
//   step    in   3  current micro-step
//   cf      in   1  carry flag (only consulted by JC at T2)
//   zf      in   1  zero flag (only consulted by JZ at T2)
//   cw      out  -  control word (ctrl_t, active-high fields)
//   last    out  1  this step is the final step of the instruction
module microcode_rom
  import control_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [2:0] step,
  input  logic       cf,
  input  logic       zf,
  output ctrl_t      cw,
  output logic       last
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value held, which would otherwise infer a latch.
    cw   = CTRL_IDLE;
    last = 1'b0;

    unique case (step)
      // Fetch is common to all instructions and ignores the opcode, which
      // is still the previous instruction's until the T1 edge loads ii.
      T0: begin
        cw.co = 1'b1;
        cw.mi = 1'b1;
      end

      T1: begin
        cw.ro = 1'b1;
        cw.ii = 1'b1;
        cw.ce = 1'b1;
      end

      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw.io = 1'b1;
            cw.mi = 1'b1;
          end
          OP_LDI: begin
            cw.io = 1'b1;
            cw.ai = 1'b1;
            last  = 1'b1;
          end
          OP_JMP: begin
            cw.io = 1'b1;
            cw.j  = 1'b1;
            last  = 1'b1;
          end
          // Conditional jumps always put the operand on the bus; only the
          // PC load depends on the flag, so the length is fixed at 3.
          OP_JC: begin
            cw.io = 1'b1;
            cw.j  = cf;
            last  = 1'b1;
          end
          OP_JZ: begin
            cw.io = 1'b1;
            cw.j  = zf;
            last  = 1'b1;
          end
          OP_OUT: begin
            cw.ao = 1'b1;
            cw.oi = 1'b1;
            last  = 1'b1;
          end
          OP_HLT: begin
            cw.hlt = 1'b1;
            last   = 1'b1;
          end
          // NOP and the unassigned opcodes: one empty execute step.
          default: last = 1'b1;
        endcase
      end

      T3: begin
        case (opcode)
          OP_LDA: begin
            cw.ro = 1'b1;
            cw.ai = 1'b1;
            last  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw.ro = 1'b1;
            cw.bi = 1'b1;
          end
          OP_STA: begin
            cw.ao = 1'b1;
            cw.ri = 1'b1;
            last  = 1'b1;
          end
          // Not reachable for a well-formed sequence; wrap defensively.
          default: last = 1'b1;
        endcase
      end

      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw.eo = 1'b1;
          cw.ai = 1'b1;
          cw.fi = 1'b1;
          cw.su = (opcode == OP_SUB);
        end
        last = 1'b1;
      end

      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer for the 8-bit CPU. Holds the micro-step counter and the
// halt register, and gates the microcode ROM output with reset and halt.
// Control outputs are combinational from the registered state and the
// opcode/flag inputs; the datapath samples them on the next rising edge.
//
// Ports:
//   clk     in   1  system clock, rising-edge
//   clr_n   in   1  asynchronous active-low reset
//   opcode  in   4  instruction register upper nibble
//   cf, zf  in   1  carry / zero flags
//   mi ri ro ii io ai ao bi eo su fi oi ce j hlt
//           out  1  active-high control strobes
//   co_n    out  1  program counter drives bus (active-low)
//   step    out  3  current micro-step (debug)
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int MAX_STEP = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       ii,
  output logic       io,
  output logic       ai,
  output logic       ao,
  output logic       bi,
  output logic       eo,
  output logic       su,
  output logic       fi,
  output logic       oi,
  output logic       ce,
  output logic       j,
  output logic       co_n,
  output logic       hlt,
  output logic [2:0] step
);

  localparam logic [2:0] LAST_STEP = 3'(MAX_STEP);

  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;
  ctrl_t      rom_cw;
  logic       rom_last;
  ctrl_t      ctrl;

  microcode_rom u_rom (
    .opcode (opcode),
    .step   (step_q),
    .cf     (cf),
    .zf     (zf),
    .cw     (rom_cw),
    .last   (rom_last)
  );

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all clocked state, so every
      // register samples the pre-edge values regardless of statement order.
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic. Once halted the counter freezes at T2; only reset
  // leaves the halted state.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (step_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (rom_last || step_q == LAST_STEP) begin
        step_d = T0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  // Output gating. Reset is applied combinationally so an instruction
  // aborted mid-step drops its strobes in the same cycle clr_n falls.
  always_comb begin
    ctrl = rom_cw;
    if (!clr_n) begin
      ctrl = CTRL_IDLE;
    end else if (halted_q) begin
      ctrl     = CTRL_IDLE;
      ctrl.hlt = 1'b1;
    end
  end

  assign mi   = ctrl.mi;
  assign ri   = ctrl.ri;
  assign ro   = ctrl.ro;
  assign ii   = ctrl.ii;
  assign io   = ctrl.io;
  assign ai   = ctrl.ai;
  assign ao   = ctrl.ao;
  assign bi   = ctrl.bi;
  assign eo   = ctrl.eo;
  assign su   = ctrl.su;
  assign fi   = ctrl.fi;
  assign oi   = ctrl.oi;
  assign ce   = ctrl.ce;
  assign j    = ctrl.j;
  assign co_n = ~ctrl.co;
  assign hlt  = ctrl.hlt;
  assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. A behavioural model tracks the
// expected micro-step from instruction lengths and derives the expected
// control word from per-instruction micro-op tables; a compare process
// checks every falling edge, and directed sequences pin literal values.
module tb_control_sequencer;

  // Bit masks for the packed comparison vector (co is active-high here).
  localparam logic [15:0] M_MI  = 16'h8000;
  localparam logic [15:0] M_RI  = 16'h4000;
  localparam logic [15:0] M_RO  = 16'h2000;
  localparam logic [15:0] M_II  = 16'h1000;
  localparam logic [15:0] M_IO  = 16'h0800;
  localparam logic [15:0] M_AI  = 16'h0400;
  localparam logic [15:0] M_AO  = 16'h0200;
  localparam logic [15:0] M_BI  = 16'h0100;
  localparam logic [15:0] M_EO  = 16'h0080;
  localparam logic [15:0] M_SU  = 16'h0040;
  localparam logic [15:0] M_FI  = 16'h0020;
  localparam logic [15:0] M_OI  = 16'h0010;
  localparam logic [15:0] M_CE  = 16'h0008;
  localparam logic [15:0] M_J   = 16'h0004;
  localparam logic [15:0] M_CO  = 16'h0002;
  localparam logic [15:0] M_HLT = 16'h0001;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [3:0] opcode;
  logic       cf, zf;
  logic       mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, ce, j, co_n, hlt;
  logic [2:0] step;

  int n_checks = 0;
  int n_errors = 0;

  control_sequencer #(.MAX_STEP(4)) dut (
    .clk(clk), .clr_n(clr_n), .opcode(opcode), .cf(cf), .zf(zf),
    .mi(mi), .ri(ri), .ro(ro), .ii(ii), .io(io), .ai(ai), .ao(ao),
    .bi(bi), .eo(eo), .su(su), .fi(fi), .oi(oi), .ce(ce), .j(j),
    .co_n(co_n), .hlt(hlt), .step(step)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, ce, j, ~co_n, hlt};
  endfunction

  // ---------------- behavioural model ----------------
  // Total steps an instruction occupies, fetch included.
  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Execute micro-op k (0 = T2) of an instruction.
  function automatic logic [15:0] exec_word(input logic [3:0] op, input int k,
                                            input logic c, input logic z);
    logic [15:0] add_seq [3];
    add_seq = '{M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI};
    case (op)
      4'h1: return (k == 0) ? (M_IO | M_MI) : (M_RO | M_AI);
      4'h2: return add_seq[k];
      4'h3: return (k == 2) ? (add_seq[k] | M_SU) : add_seq[k];
      4'h4: return (k == 0) ? (M_IO | M_MI) : (M_AO | M_RI);
      4'h5: return M_IO | M_AI;
      4'h6: return M_IO | M_J;
      4'h7: return c ? (M_IO | M_J) : M_IO;
      4'h8: return z ? (M_IO | M_J) : M_IO;
      4'hE: return M_AO | M_OI;
      4'hF: return M_HLT;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] exp_vec(input logic [3:0] op, input logic [2:0] st,
                                          input logic c, input logic z,
                                          input logic halted, input logic rn);
    if (!rn)     return 16'h0000;
    if (halted)  return M_HLT;
    if (st == 0) return M_CO | M_MI;
    if (st == 1) return M_RO | M_II | M_CE;
    return exec_word(op, int'(st) - 2, c, z);
  endfunction

  logic [2:0] m_step;
  logic       m_halted;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_step   <= 3'd0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (m_step == 3'd2 && opcode == 4'hF)
        m_halted <= 1'b1;
      else if (int'(m_step) + 1 == instr_len(opcode))
        m_step <= 3'd0;
      else
        m_step <= m_step + 3'd1;
    end
  end

  always @(negedge clk) begin
    check("step", {29'd0, step}, {29'd0, m_step});
    check("ctrl", {16'd0, dut_vec()},
          {16'd0, exp_vec(opcode, m_step, cf, zf, m_halted, clr_n)});
    check("bus_single_driver",
          {31'd0, ($countones({~co_n, ro, io, ao, eo}) <= 1)}, 32'd1);
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] lg_vec [8];
  logic [2:0]  lg_step [8];
  int          lg_n;

  task automatic log_now();
    if (lg_n < 8) begin
      lg_vec[lg_n]  = dut_vec();
      lg_step[lg_n] = step;
      lg_n++;
    end
  endtask

  // Runs one instruction starting at T0 (called just after a rising edge).
  // Garbage opcode/flags during fetch; the real opcode appears after the
  // T1 edge. Logs each step until step returns to 0 or the budget expires.
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
    lg_n   = 0;
    opcode = 4'($urandom_range(0, 15));
    cf     = 1'($urandom_range(0, 1));
    zf     = 1'($urandom_range(0, 1));
    #1 log_now();                          // T0
    @(posedge clk); #1 log_now();          // T1
    @(posedge clk); #1;
    opcode = op; cf = c; zf = z;
    #1 log_now();                          // T2
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      log_now();
      if (step == 3'd0) break;
    end
  endtask

  initial begin
    clr_n = 1'b0; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_step", {29'd0, step}, 32'd0);
    check("rst_co_n", {31'd0, co_n}, 32'd1);
    check("rst_ctrl", {16'd0, dut_vec()}, 32'd0);

    clr_n = 1'b1;
    #1;
    check("t0_co_n", {31'd0, co_n}, 32'd0);
    check("t0_mi", {31'd0, mi}, 32'd1);
    @(posedge clk); #1;
    check("t1_step", {29'd0, step}, 32'd1);
    check("t1_ctrl", {16'd0, dut_vec()}, {16'd0, M_RO | M_II | M_CE});
    @(posedge clk); #1;  // T2 of NOP (opcode 0)
    @(posedge clk); #1;  // back at T0
    check("nop_wrap", {29'd0, step}, 32'd0);

    // ADD: steps 0,1,2,3,4,0
    run_instr(4'h2, 1'b0, 1'b0);
    check("add_len", lg_n, 32'd6);
    check("add_steps", {14'd0, lg_step[0], lg_step[1], lg_step[2], lg_step[3], lg_step[4], lg_step[5]},
          {14'd0, 18'o012340});
    check("add_t4", {16'd0, lg_vec[4]}, {16'd0, M_EO | M_AI | M_FI});

    // SUB: same sequence with su at T4
    run_instr(4'h3, 1'b0, 1'b0);
    check("sub_len", lg_n, 32'd6);
    check("sub_t4", {16'd0, lg_vec[4]}, {16'd0, M_EO | M_AI | M_FI | M_SU});

    // JC untaken / taken
    run_instr(4'h7, 1'b0, 1'b1);
    check("jc0_t2", {16'd0, lg_vec[2]}, {16'd0, M_IO});
    check("jc0_steps", {20'd0, lg_step[0], lg_step[1], lg_step[2], lg_step[3]}, {20'd0, 12'o0120});
    run_instr(4'h7, 1'b1, 1'b0);
    check("jc1_t2", {16'd0, lg_vec[2]}, {16'd0, M_IO | M_J});
    run_instr(4'h8, 1'b0, 1'b1);
    check("jz1_t2", {16'd0, lg_vec[2]}, {16'd0, M_IO | M_J});

    // LDA / STA
    run_instr(4'h1, 1'b0, 1'b0);
    check("lda_len", lg_n, 32'd5);
    check("lda_t3", {16'd0, lg_vec[3]}, {16'd0, M_RO | M_AI});
    run_instr(4'h4, 1'b0, 1'b0);
    check("sta_t3", {16'd0, lg_vec[3]}, {16'd0, M_AO | M_RI});

    // Undefined opcodes 9..D behave as NOP
    for (int op = 9; op <= 13; op++) begin
      run_instr(4'(op), 1'b1, 1'b1);
      check("undef_len", lg_n, 32'd4);
      check("undef_t2", {16'd0, lg_vec[2]}, 32'd0);
    end

    // Every non-halting opcode with every flag combination
    for (int op = 0; op < 15; op++) begin
      for (int f = 0; f < 4; f++) begin
        run_instr(4'(op), f[0], f[1]);
        check("all_len", lg_n, 32'(instr_len(4'(op)) + 1));
      end
    end

    // Reset in the middle of LDA at T3
    opcode = 4'hA;
    #1;
    @(posedge clk); #1;           // T1
    @(posedge clk); #1;
    opcode = 4'h1;                // T2
    @(posedge clk); #1;           // T3
    check("lda_mid_t3", {16'd0, dut_vec()}, {16'd0, M_RO | M_AI});
    clr_n = 1'b0;
    #1;
    check("lda_abort_ctrl", {16'd0, dut_vec()}, 32'd0);
    check("lda_abort_step", {29'd0, step}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    clr_n = 1'b1;
    #1;
    check("lda_rel_t0", {16'd0, dut_vec()}, {16'd0, M_CO | M_MI});

    // HLT: hlt at T2, then frozen for 20 more cycles
    run_instr(4'hF, 1'b0, 1'b0);
    check("hlt_t2", {16'd0, lg_vec[2]}, {16'd0, M_HLT});
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("hlt_hold", {13'd0, step, dut_vec()}, {13'd0, 3'd2, M_HLT});
    end
    clr_n = 1'b0;
    #1;
    check("hlt_rst", {16'd0, dut_vec()}, 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    #1;
    check("hlt_resume_t0", {13'd0, step, dut_vec()}, {13'd0, 3'd0, M_CO | M_MI});
    run_instr(4'h5, 1'b0, 1'b0);
    check("ldi_after_hlt", {16'd0, lg_vec[2]}, {16'd0, M_IO | M_AI});

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
